// File: rtl/bitonic_out_buffer_4.sv
// bitonic_out_buffer_4: output stage behind the 8-input bitonic merge network.
// It captures the sorted lower tuple, or both tuples when a run is flushed, into a tuple FIFO.
// The upper tuple is returned to the feeder as feedback.
// A registered stall request throttles the network early enough to cover its 3-stage latency.
// Optional feature macro: ORDER_CHECK_EN adds the sticky ascending-order checker output
// o_order_err.
module bitonic_out_buffer_4 #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned SLACK = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_stall,
    input  logic                     i_switch_output,
    input  logic [4*W-1:0]           i_elems_0,
    input  logic [4*W-1:0]           i_elems_1,
    output logic                     o_stall_req,
    output logic [4*W-1:0]           o_fb_elems,
    output logic                     o_fb_valid,
    output logic                     o_fb_clear,
    output logic [4*W-1:0]           o_data,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow
`ifdef ORDER_CHECK_EN
    ,
    output logic                     o_order_err
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] StallThr = CW'(DEPTH - SLACK);

    logic [4*W-1:0] r_mem [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           r_overflow;
    logic           r_stall_req;
    logic [4*W-1:0] r_fb_elems;
    logic           r_fb_valid;
    logic           r_fb_clear;

    logic           w_accept;
    logic [1:0]     w_push_n;
    logic           w_pop;
    logic [CW-1:0]  w_space;
    logic           w_push_ok;
    logic [CW-1:0]  w_count_next;
    logic [PW-1:0]  w_wr_ptr_1;

    // In-flight network data is ignored while reset is held.
    always_comb begin
        w_accept     = ~i_stall & ~i_rst;
        w_push_n     = w_accept ? (i_switch_output ? 2'd2 : 2'd1) : 2'd0;
        w_pop        = (r_count != '0) & i_ready;
        w_space      = CW'(DEPTH) - r_count + CW'(w_pop);
        // A flush that does not fit is dropped whole, never split.
        w_push_ok    = (w_push_n != 2'd0) && (CW'(w_push_n) <= w_space);
        w_count_next = r_count + (w_push_ok ? CW'(w_push_n) : '0) - CW'(w_pop);
        w_wr_ptr_1   = r_wr_ptr + PW'(1);
    end

    // Tuple storage; contents are meaningless until counted in r_count.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_elems_0;
            if (i_switch_output) begin
                r_mem[w_wr_ptr_1] <= i_elems_1;
            end
        end
    end

    // Pointers, occupancy, overflow flag and the registered stall request.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_stall_req <= 1'b1;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PW'(w_push_n);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if ((w_push_n != 2'd0) && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
            r_count     <= w_count_next;
            r_stall_req <= (w_count_next > StallThr);
        end
    end

    // Feedback path: upper tuple on a normal accept, clear pulse when the run ends.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fb_elems <= '0;
            r_fb_valid <= 1'b0;
            r_fb_clear <= 1'b0;
        end else begin
            r_fb_valid <= w_accept & ~i_switch_output;
            r_fb_clear <= w_accept & i_switch_output;
            if (w_accept && !i_switch_output) begin
                r_fb_elems <= i_elems_1;
            end
        end
    end

`ifdef ORDER_CHECK_EN
    logic           r_order_err;
    logic           r_run_active;
    logic [W-1:0]   r_prev_hi;
    logic           w_violation;

    function automatic logic is_ascending(input logic [4*W-1:0] t);
        return (t[W-1:0] <= t[2*W-1:W]) && (t[2*W-1:W] <= t[3*W-1:2*W]) &&
               (t[3*W-1:2*W] <= t[4*W-1:3*W]);
    endfunction

    // Ordering within each tuple, across the two flushed tuples and against the prior push.
    always_comb begin
        w_violation = 1'b0;
        if (w_accept) begin
            if (!is_ascending(i_elems_0)) begin
                w_violation = 1'b1;
            end
            if (r_run_active && (i_elems_0[W-1:0] < r_prev_hi)) begin
                w_violation = 1'b1;
            end
            if (i_switch_output &&
                (!is_ascending(i_elems_1) || (i_elems_1[W-1:0] < i_elems_0[4*W-1:3*W]))) begin
                w_violation = 1'b1;
            end
        end
    end

    // Run tracking and the sticky order error.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_order_err  <= 1'b0;
            r_run_active <= 1'b0;
            r_prev_hi    <= '0;
        end else begin
            if (w_violation) begin
                r_order_err <= 1'b1;
            end
            if (w_accept) begin
                r_run_active <= ~i_switch_output;
                r_prev_hi    <= i_elems_0[4*W-1:3*W];
            end
        end
    end

    assign o_order_err = r_order_err;
`endif

    assign o_stall_req = r_stall_req;
    assign o_fb_elems  = r_fb_elems;
    assign o_fb_valid  = r_fb_valid;
    assign o_fb_clear  = r_fb_clear;
    assign o_data      = r_mem[r_rd_ptr];
    assign o_valid     = (r_count != '0);
    assign o_count     = r_count;
    assign o_overflow  = r_overflow;

endmodule
